uart_imem_dump: RTL

- Readback path for UART instruction-memory programming: reads N consecutive 32-bit words from instruction memory and transmits them on a UART TX line.
- Frame format: 8N1. Words are sent byte 0 (bits 7:0) first, so a host can compare the stream byte-for-byte with what it downloaded.
- Sits beside the UART peripheral, sharing the imem read port while the CPU is stalled. Started by a control pulse from the UART control logic.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_byte.sv | 86 ++++++++
 rtl/uart_imem_dump.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: dumper/serializer state encoding, baud divisor helper
// and the UART peripheral memory map.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5,
    NEXT  = 3'd6
  } state_t;

  localparam logic [31:0] UART_DATA_ADDR   = 32'h8000_0004;
  localparam logic [31:0] UART_CTRL_ADDR   = 32'h8000_0008;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h8000_000C;

  function automatic int baud_count(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. Owns start/data/stop bit timing; ready also rises in the
// last stop-bit cycle so a back-to-back load produces no idle gap between bytes.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_COUNT = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] data,
  output logic       TX,
  output logic       ready
);

  state_t      phase;
  logic [7:0]  shift;
  logic [3:0]  bit_cnt;
  logic [15:0] baud_cnt;
  logic        last_tick;

  assign last_tick = (baud_cnt == 16'(BAUD_COUNT - 1));
  assign ready     = (phase == IDLE) || ((phase == STOP) && last_tick);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      phase    <= IDLE;
      TX       <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else if (clear) begin
      phase    <= IDLE;
      TX       <= 1'b1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else if (load && ready) begin
      phase    <= START;
      TX       <= 1'b0;
      shift    <= data;
      bit_cnt  <= 4'd8;
      baud_cnt <= '0;
    end else begin
      case (phase)
        START: begin
          if (last_tick) begin
            phase    <= DATA;
            TX       <= shift[0];
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (last_tick) begin
            shift    <= {1'b0, shift[7:1]};
            bit_cnt  <= bit_cnt - 4'd1;
            baud_cnt <= '0;
            if (bit_cnt == 4'd1) begin
              phase <= STOP;
              TX    <= 1'b1;
            end else begin
              TX <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (last_tick) begin
            phase    <= IDLE;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          phase <= IDLE;
          TX    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_imem_dump.sv
// Reads word_count consecutive imem words and streams them out over 8N1 UART,
// byte 0 first. While a word is on the wire the FSM sits in START.
module uart_imem_dump
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 5_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  output logic        mem_RE,
  output logic [31:0] mem_A,
  input  logic [31:0] mem_RD,
  output logic        TX,
  output logic        busy,
  output logic        done
);

  localparam int BAUD_COUNT = baud_count(CLK_FREQ, BAUD_RATE);

  state_t      state;
  logic [31:0] addr;
  logic [31:0] word;
  logic [15:0] remaining;
  logic [1:0]  byte_idx;
  logic [1:0]  next_idx;
  logic        ser_load;
  logic [7:0]  ser_data;
  logic        ser_ready;

  assign next_idx = byte_idx + 2'd1;

  // Byte 0 comes straight off mem_RD so the start bit begins the cycle after WAIT.
  always_comb begin
    ser_load = 1'b0;
    ser_data = word[{next_idx, 3'b000} +: 8];
    if (!abort) begin
      if (state == WAIT) begin
        ser_load = 1'b1;
        ser_data = mem_RD[7:0];
      end else if (state == START && ser_ready && byte_idx != 2'd3) begin
        ser_load = 1'b1;
      end
    end
  end

  uart_tx_byte #(.BAUD_COUNT(BAUD_COUNT)) u_tx (
    .CLK   (CLK),
    .reset (reset),
    .clear (abort),
    .load  (ser_load),
    .data  (ser_data),
    .TX    (TX),
    .ready (ser_ready)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      word      <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_RE    <= 1'b0;
      mem_A     <= '0;
    end else begin
      done   <= 1'b0;
      mem_RE <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (word_count != 16'd0) begin
                addr      <= base_addr & 32'hFFFF_FFFC;
                mem_A     <= base_addr & 32'hFFFF_FFFC;
                mem_RE    <= 1'b1;
                remaining <= word_count;
                byte_idx  <= 2'd0;
                busy      <= 1'b1;
                state     <= FETCH;
              end else begin
                done <= 1'b1;
              end
            end
          end
          FETCH: state <= WAIT;
          WAIT: begin
            word  <= mem_RD;
            state <= START;
          end
          START: begin
            if (ser_ready) begin
              if (byte_idx != 2'd3) byte_idx <= next_idx;
              else                  state    <= NEXT;
            end
          end
          NEXT: begin
            remaining <= remaining - 16'd1;
            addr      <= addr + 32'd4;
            if (remaining == 16'd1) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              byte_idx <= 2'd0;
              mem_A    <= addr + 32'd4;
              mem_RE   <= 1'b1;
              state    <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
